// File: rtl/mul32_rr_arbiter.sv
// Round-robin arbiter that shares one combinational 32x32 multiplier among NUM_REQ clients.
// Define MUL32_ARB_SIGNED_EN to add per-request signed operands (req_signed port).

module multiplier_32bits_version10 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] p_o
);
    logic [63:0] acc;

    // Shift-and-add array: one partial product row per bit of b_i.
    always_comb begin
        acc = '0;
        for (int k = 0; k < 32; k++) begin
            if (b_i[k]) begin
                acc = acc + ({32'd0, a_i} << k);
            end
        end
    end

    assign p_o = acc;
endmodule

module mul32_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int MUL_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
`ifdef MUL32_ARB_SIGNED_EN
    input  logic [NUM_REQ-1:0]      req_signed,
`endif
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [63:0]             resp_product,
    output logic                    busy,
    output logic [1:0]              dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // req_ready is only offered in IDLE; resp_valid stays high with stable data until resp_ready.

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [31:0]       op_a_q, op_a_d;
    logic [31:0]       op_b_q, op_b_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       product_q, product_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic [ID_W:0]      scan;
    logic [ID_W-1:0]    ptr_next;
    logic [31:0]        sel_a, sel_b;

    logic [31:0]        mag_a, mag_b;
    logic [63:0]        mul_p;
    logic [63:0]        capture_val;

    // Rotating priority search starting at rr_ptr_q, wrapping past NUM_REQ-1 to 0.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(NUM_REQ)) begin
                scan = scan - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_any && req_valid[scan[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan[ID_W-1:0];
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign sel_a    = req_a[32*int'(grant_idx) +: 32];
    assign sel_b    = req_b[32*int'(grant_idx) +: 32];

`ifdef MUL32_ARB_SIGNED_EN
    logic sgn_q, sgn_d;
    logic neg;

    // Multiply magnitudes, then restore the sign on the captured product.
    assign mag_a       = (sgn_q && op_a_q[31]) ? (~op_a_q + 32'd1) : op_a_q;
    assign mag_b       = (sgn_q && op_b_q[31]) ? (~op_b_q + 32'd1) : op_b_q;
    assign neg         = sgn_q & (op_a_q[31] ^ op_b_q[31]);
    assign capture_val = neg ? (~mul_p + 64'd1) : mul_p;
`else
    assign mag_a       = op_a_q;
    assign mag_b       = op_b_q;
    assign capture_val = mul_p;
`endif

    multiplier_32bits_version10 u_mul (
        .a_i (mag_a),
        .b_i (mag_b),
        .p_o (mul_p)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_any)        state_d = ST_MUL;
            ST_MUL:  if (cnt_q == '0)      state_d = ST_RESP;
            ST_RESP: if (resp_ready)       state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // Output logic; req_ready is forced low while reset is held.
    always_comb begin
        req_ready    = '0;
        resp_valid   = 1'b0;
        busy         = 1'b1;
        if (state_q == ST_IDLE) begin
            busy = 1'b0;
            if (rst_n) begin
                req_ready = grant;
            end
        end
        if (state_q == ST_RESP) begin
            resp_valid = 1'b1;
        end
        resp_id      = resp_id_q;
        resp_product = product_q;
        dbg_state    = state_q;
    end

    // Datapath next-state: latch on request handshake, count down, capture product.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        resp_id_d = resp_id_q;
`ifdef MUL32_ARB_SIGNED_EN
        sgn_d     = sgn_q;
`endif
        if (state_q == ST_IDLE && grant_any) begin
            op_a_d   = sel_a;
            op_b_d   = sel_b;
            id_d     = grant_idx;
            rr_ptr_d = ptr_next;
            cnt_d    = CNT_INIT;
`ifdef MUL32_ARB_SIGNED_EN
            sgn_d    = req_signed[grant_idx];
`endif
        end else if (state_q == ST_MUL) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                product_d = capture_val;
                resp_id_d = id_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            resp_id_q <= '0;
`ifdef MUL32_ARB_SIGNED_EN
            sgn_q     <= 1'b0;
`endif
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            resp_id_q <= resp_id_d;
`ifdef MUL32_ARB_SIGNED_EN
            sgn_q     <= sgn_d;
`endif
        end
    end
endmodule

// File: tb/tb_mul32_rr_arbiter.sv
// Directed + randomized bench for mul32_rr_arbiter with a behavioural reference model.
// Signed cases are compiled in when MUL32_ARB_SIGNED_EN is defined.

module tb_mul32_rr_arbiter;
    localparam int N    = 4;
    localparam int ID_W = 2;
    localparam int MC   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic [N-1:0]      req_sgn;
    logic              resp_valid;
    logic              resp_ready;
    logic [ID_W-1:0]   resp_id;
    logic [63:0]       resp_product;
    logic              busy;
    logic [1:0]        dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int last_grant;
    logic [63:0] exp_q[$];

    // Clock / reset
    always #5 clk = ~clk;

    mul32_rr_arbiter #(.NUM_REQ(N), .ID_W(ID_W), .MUL_CYCLES(MC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
`ifdef MUL32_ARB_SIGNED_EN
        .req_signed   (req_sgn),
`endif
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the requester after the last grant has top priority.
    function automatic int model_grant(input logic [N-1:0] vld);
        for (int k = 1; k <= N; k++) begin
            if (vld[(last_grant + k) % N]) return (last_grant + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [63:0] model_product(input logic [31:0] a, input logic [31:0] b,
                                                  input logic sgn);
        longint sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Driver: caller is at a falling edge with operands set; one full transaction.
    task automatic run_txn(input logic [N-1:0] vld, input int hold, input bit scramble);
        int          g;
        logic [63:0] exp_p;
        req_valid  = vld;
        resp_ready = (hold == 0);
        #1;
        g = model_grant(vld);
        if (g < 0) begin
            $display("FAIL run_txn: no requester asserted, observed=0x%0h required=nonzero", vld);
            tests_failed++;
            return;
        end
        check("grant_onehot", 64'(req_ready), 64'(1) << g);
        check("idle_busy", 64'(busy), 64'd0);
        exp_q.push_back(model_product(req_a[32*g +: 32], req_b[32*g +: 32], req_sgn[g]));
        last_grant = g;
        @(posedge clk);
        @(negedge clk);
        if (scramble) begin
            req_a[32*g +: 32] = $urandom;
            req_b[32*g +: 32] = $urandom;
        end
        for (int c = 0; c < MC; c++) begin
            if (c > 0) @(negedge clk);
            check("mul_resp_valid", 64'(resp_valid), 64'd0);
            check("mul_busy", 64'(busy), 64'd1);
            check("mul_req_ready", 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        exp_p = exp_q.pop_front();
        check("resp_valid_latency", 64'(resp_valid), 64'd1);
        check("resp_id", 64'(resp_id), 64'(g));
        check("resp_product", resp_product, exp_p);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bp_resp_valid", 64'(resp_valid), 64'd1);
            check("bp_product", resp_product, exp_p);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("post_resp_valid", 64'(resp_valid), 64'd0);
        check("post_busy", 64'(busy), 64'd0);
        check("post_product_hold", resp_product, exp_p);
    endtask

    task automatic idle_cycle();
        req_valid = '0;
        #1;
        check("idle_req_ready", 64'(req_ready), 64'd0);
        check("idle_resp_valid", 64'(resp_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        check("rst_resp_product", resp_product, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [N-1:0] vld;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_sgn    = '0;
        resp_ready = 1'b0;
        last_grant = N - 1;

        // Reset and idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) idle_cycle();
        check_reset_outputs();

        // Single unsigned operation on requester 0
        req_a[31:0] = 32'h3489BE8F;
        req_b[31:0] = 32'hFFFFFFFF;
        run_txn(4'b0001, 0, 1'b1);
        check("vec_single", resp_product, 64'h3489BE8ECB764171);

        // Backpressure for 10 cycles
        req_a[95:64] = 32'hFFFFFFFF;
        req_b[95:64] = 32'hFFFFFFFF;
        run_txn(4'b0100, 10, 1'b1);
        check("vec_backpressure", resp_product, 64'hFFFFFFFE00000001);

        // Zero operand
        req_a[63:32] = 32'd0;
        req_b[63:32] = $urandom;
        run_txn(4'b0010, 1, 1'b0);
        check("vec_zero", resp_product, 64'd0);

        // Randomized traffic: random requester subsets, operands, backpressure
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                req_a[32*i +: 32] = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
                req_b[32*i +: 32] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            end
            vld = N'($urandom_range(1, (1 << N) - 1));
            run_txn(vld, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

`ifdef MUL32_ARB_SIGNED_EN
        req_sgn      = 4'b1000;
        req_a[127:96] = 32'hFFFFFFFD;
        req_b[127:96] = 32'd7;
        run_txn(4'b1000, 0, 1'b0);
        check("vec_signed_neg", resp_product, 64'hFFFFFFFFFFFFFFEB);
        req_a[127:96] = 32'h80000000;
        req_b[127:96] = 32'h80000000;
        run_txn(4'b1000, 0, 1'b0);
        check("vec_signed_min", resp_product, 64'h4000000000000000);
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++) begin
                req_a[32*i +: 32] = $urandom;
                req_b[32*i +: 32] = $urandom;
            end
            req_sgn = N'($urandom_range(0, (1 << N) - 1));
            vld = N'($urandom_range(1, (1 << N) - 1));
            run_txn(vld, $urandom_range(0, 2), 1'b0);
        end
        req_sgn = '0;
`endif

        // Reset while in MUL: in-flight product discarded, pointer back to 0
        req_a[95:64] = 32'h12345678;
        req_b[95:64] = 32'h9ABCDEF0;
        req_valid    = 4'b0100;
        resp_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        req_valid = '1;
        rst_n     = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst_n      = 1'b1;
        last_grant = N - 1;
        for (int i = 0; i < MC + 2; i++) idle_cycle();
        check("post_rst_product", resp_product, 64'd0);

        // Round robin with all requesters continuously valid
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = 32'(i + 1);
            req_b[32*i +: 32] = 32'hFFFFFFFF;
        end
        for (int t = 0; t < N + 1; t++) begin
            run_txn('1, 0, 1'b0);
            check("rr_order", 64'(resp_id), 64'(t % N));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mul32_rr_arbiter.md
Name: mul32_rr_arbiter

Overview:
- Shares one 32x32 combinational multiplier (multiplier_32bits_version10) between NUM_REQ requesters.
- Round-robin arbitration with valid/ready handshakes on both request and response sides.
- Holds the multiplier's operands stable for MUL_CYCLES clocks so the combinational array settles, then registers the 64-bit product.
- Returns the product tagged with the requester's ID; sits between client engines and the shared multiplier datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of resp_id; must satisfy 2**ID_W >= NUM_REQ.
- MUL_CYCLES, 2, clocks the operands are held before the product is captured (>=1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*32  operand A; requester i uses bits [32i+31:32i].
- req_b  input  NUM_REQ*32  operand B, same packing as req_a.
- resp_valid  output  1  product valid.
- resp_ready  input  1  consumer accepts the product.
- resp_id  output  ID_W  index of the requester that owns the product.
- resp_product  output  64  A*B.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_id=0, resp_product=0, busy=0, operand registers=0.
- States:
  - IDLE: req_ready is combinational. It is one-hot to the first asserted req_valid, searching upward from rr_ptr with wrap-around (index NUM_REQ-1 wraps to 0). It is 0 when no req_valid is set.
    - Handshake in cycle T = req_valid[i] & req_ready[i].
    - At the end-of-T edge: latch req_a[i] and req_b[i] into operand registers, latch id=i, set rr_ptr=(i+1) mod NUM_REQ, cnt=MUL_CYCLES-1, state->MUL.
  - MUL: operand registers drive the multiplier unchanged. If cnt!=0, decrement cnt. If cnt==0, register the product into resp_product and resp_id, then state->RESP.
  - RESP: resp_valid=1; resp_product and resp_id are held stable. On resp_valid & resp_ready, state->IDLE and resp_valid falls next cycle. resp_product keeps its last value.
- Latency: handshake in cycle T -> resp_valid first high in cycle T+MUL_CYCLES+1.
- Occupancy: one operation at a time. req_ready=0 in MUL and RESP. The earliest next handshake is the cycle after the response handshake. Peak throughput is one product per MUL_CYCLES+2 clocks.
- Arithmetic: unsigned 32x32 gives a full 64-bit product with no truncation. 0 times anything = 0.
- Fairness: the last granted requester becomes lowest priority. With all requesters asserting continuously, grants rotate 0,1,2,3,0,...
- Requester inputs are sampled only in the handshake cycle. Changes afterwards have no effect.
- A requester dropping req_valid before being granted is legal; that request is never seen.
- Backpressure: resp_ready may stay low indefinitely; the block stays in RESP with outputs stable.
- Reset asserted mid-operation immediately forces all reset values; the in-flight product is discarded and no response is issued.
- NUM_REQ=1: arbitration degenerates to a pass-through grant; rr_ptr stays 0.

Optional Feature:
- Macro: MUL32_ARB_SIGNED_EN.
- Defined:
  - Adds input req_signed [NUM_REQ-1:0], latched with the operands.
  - Signed operands are converted to magnitudes before the multiplier.
  - The product is two's-complement negated at capture when sign(A) XOR sign(B) is set.
  - -2^31 * -2^31 must yield 0x4000000000000000.
  - Adds no cycles.
- Not defined: the port is absent and all operations are unsigned.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles then 1, no requests -> all outputs 0, busy=0, req_ready=0.
- Single unsigned op, MUL_CYCLES=2: req 0, A=0x3489BE8F, B=0xFFFFFFFF, handshake at T -> resp_valid at T+3, resp_product=0x3489BE8ECB764171, resp_id=0.
- Round-robin: all 4 requesters valid continuously with A=i+1, B=0xFFFFFFFF, resp_ready=1 -> grant order 0,1,2,3,0. The first four products are (i+1)*0xFFFFFFFF, tagged with the matching IDs.
- Backpressure: resp_ready=0 for 10 cycles with A=B=0xFFFFFFFF -> resp_valid held and product stable at 0xFFFFFFFE00000001; no req_ready; completes on the first resp_ready=1.
- Reset mid-op: assert rst_n=0 in the MUL state -> outputs 0 immediately; after release, no stale resp_valid appears and the next grant starts from requester 0.
- MUL32_ARB_SIGNED_EN: A=0xFFFFFFFD (-3), B=7, signed -> 0xFFFFFFFFFFFFFFEB. With A=B=0x80000000 signed -> 0x4000000000000000.
